// File: rtl/stop_watch_pkg.sv
// stop_watch_pkg: shared stopwatch constants and the {min,sec,cs} BCD time type
package stop_watch_pkg;
    localparam logic [1:0] ST_ZERO     = 2'd0;
    localparam logic [1:0] ST_COUNTING = 2'd1;
    localparam logic [1:0] ST_STOP     = 2'd2;
    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    typedef struct packed {
        logic [7:0] min;
        logic [7:0] sec;
        logic [7:0] cs;
    } time_t;
endpackage

// File: rtl/stop_watch_counter_bcd_digit_pair.sv
// bcd_digit_pair: two-digit BCD counter 00..{MAX_TENS,MAX_UNITS}; clk/rst_n, inc/clr in, value/carry out
module bcd_digit_pair
    import stop_watch_pkg::*;
#(
    parameter int MAX_TENS  = CS_MAX / 10,
    parameter int MAX_UNITS = CS_MAX % 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);
    logic [7:0] value_q, value_d;
    logic       at_max;
    assign at_max = value_q == {4'(MAX_TENS), 4'(MAX_UNITS)};
    assign carry  = inc & ~clr & at_max;
    assign value  = value_q;
    always_comb begin
        value_d = clr               ? 8'h00 :
                  !inc              ? value_q :
                  at_max            ? 8'h00 :
                  value_q[3:0] == 9 ? {value_q[7:4] + 4'd1, 4'd0} :
                                      {value_q[7:4], value_q[3:0] + 4'd1};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end
endmodule

// File: rtl/stop_watch_counter.sv
// stop_watch_counter: 10 ms prescaler + BCD mm:ss.cc counter with lap-hold display
//   in : i_clk_h, i_sys_rst_l (async, low), i_watch_running_h, i_watch_rst_h, i_lap_h
//   out: o_tick_h, o_cs_bcd, o_sec_bcd, o_min_bcd, o_disp_bcd, o_lap_hold_h, o_wrap_h
module stop_watch_counter
    import stop_watch_pkg::*;
#(
    parameter int CLK_HZ  = 1000000,
    parameter int TICK_HZ = 100
) (
    input  logic        i_clk_h,
    input  logic        i_sys_rst_l,
    input  logic        i_watch_running_h,
    input  logic        i_watch_rst_h,
    input  logic        i_lap_h,
    output logic        o_tick_h,
    output logic [7:0]  o_cs_bcd,
    output logic [7:0]  o_sec_bcd,
    output logic [7:0]  o_min_bcd,
    output logic [23:0] o_disp_bcd,
    output logic        o_lap_hold_h,
    output logic        o_wrap_h
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = $clog2(DIV);
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d, wrap_q, lap_q, lap_d;
    time_t            disp_q, disp_d, live;
    logic             cs_carry, sec_carry, min_carry;
    assign tick_d = !i_watch_rst_h && i_watch_running_h && presc_q == DIV_W'(DIV - 1);
    assign live   = {o_min_bcd, o_sec_bcd, o_cs_bcd};
    always_comb begin
        presc_d = i_watch_rst_h      ? '0 :
                  !i_watch_running_h ? presc_q :
                  tick_d             ? '0 : presc_q + 1'b1;
        lap_d   = !i_watch_rst_h && (lap_q ^ i_lap_h);
        // holding and no toggle keeps the frozen value; otherwise sample the pre-edge live time
        disp_d  = i_watch_rst_h        ? '0 :
                  lap_q && !i_lap_h    ? disp_q : live;
    end
    bcd_digit_pair #(.MAX_TENS(CS_MAX / 10), .MAX_UNITS(CS_MAX % 10)) u_cs (
        .clk(i_clk_h), .rst_n(i_sys_rst_l), .inc(tick_d), .clr(i_watch_rst_h),
        .value(o_cs_bcd), .carry(cs_carry)
    );
    bcd_digit_pair #(.MAX_TENS(SEC_MAX / 10), .MAX_UNITS(SEC_MAX % 10)) u_sec (
        .clk(i_clk_h), .rst_n(i_sys_rst_l), .inc(cs_carry), .clr(i_watch_rst_h),
        .value(o_sec_bcd), .carry(sec_carry)
    );
    bcd_digit_pair #(.MAX_TENS(MIN_MAX / 10), .MAX_UNITS(MIN_MAX % 10)) u_min (
        .clk(i_clk_h), .rst_n(i_sys_rst_l), .inc(sec_carry), .clr(i_watch_rst_h),
        .value(o_min_bcd), .carry(min_carry)
    );
    always_ff @(posedge i_clk_h or negedge i_sys_rst_l) begin
        if (!i_sys_rst_l) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            lap_q   <= 1'b0;
            disp_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            wrap_q  <= min_carry;
            lap_q   <= lap_d;
            disp_q  <= disp_d;
        end
    end
    assign o_tick_h     = tick_q;
    assign o_wrap_h     = wrap_q;
    assign o_lap_hold_h = lap_q;
    assign o_disp_bcd   = disp_q;
endmodule

// File: tb/tb_stop_watch_counter.sv
// tb_stop_watch_counter: directed self-checking bench for stop_watch_counter at DIV=10
module tb_stop_watch_counter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        running = 1'b0, watch_rst = 1'b0, lap = 1'b0;
    logic        o_tick_h, o_lap_hold_h, o_wrap_h;
    logic [7:0]  o_cs_bcd, o_sec_bcd, o_min_bcd;
    logic [23:0] o_disp_bcd;
    logic [31:0] tick_mask;
    int          checks = 0, failures = 0, ticks = 0, last_tick = 0;

    stop_watch_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .i_clk_h(clk), .i_sys_rst_l(rst_n), .i_watch_running_h(running),
        .i_watch_rst_h(watch_rst), .i_lap_h(lap), .o_tick_h(o_tick_h),
        .o_cs_bcd(o_cs_bcd), .o_sec_bcd(o_sec_bcd), .o_min_bcd(o_min_bcd),
        .o_disp_bcd(o_disp_bcd), .o_lap_hold_h(o_lap_hold_h), .o_wrap_h(o_wrap_h)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_tick_h) begin
                ticks++;
                last_tick = i + 1;
            end
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_live", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h0);
        chk("rst_flags", {o_disp_bcd, o_tick_h, o_lap_hold_h, o_wrap_h}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        // 25 running cycles from clear: ticks exactly on cycles 10 and 20
        running = 1'b1;
        tick_mask = '0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (o_tick_h) tick_mask[c] = 1'b1;
        end
        chk("tick_cycles", tick_mask, 32'h0010_0400);
        chk("cs_after_25", {24'h0, o_cs_bcd}, 32'h02);
        // watch reset with running still high
        watch_rst = 1'b1;
        cyc(1);
        watch_rst = 1'b0;
        chk("wrst_live", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h0);
        chk("wrst_tick", {31'h0, o_tick_h}, 32'h0);
        // stop/resume keeps the partial tick
        ticks = 0;
        cyc(7);
        running = 1'b0;
        cyc(50);
        chk("idle_ticks", ticks, 0);
        running = 1'b1;
        cyc(3);
        chk("resume_ticks", ticks, 1);
        chk("resume_tick_pos", last_tick, 3);
        chk("resume_cs", {24'h0, o_cs_bcd}, 32'h01);
        // async reset at 00:03.47, no clock edge needed
        watch_rst = 1'b1;
        cyc(1);
        watch_rst = 1'b0;
        cyc(3470);
        chk("pre_async_live", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h000347);
        chk("pre_async_disp", {8'h0, o_disp_bcd}, 32'h000346);
        #2 rst_n = 1'b0;
        #1;
        chk("async_live", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h0);
        chk("async_flags", {o_disp_bcd, o_tick_h, o_lap_hold_h, o_wrap_h}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        // lap hold at 00:01.23 while live counts to 00:02.00
        cyc(1230);
        chk("lap_pre_live", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h000123);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk("lap_hold_on", {31'h0, o_lap_hold_h}, 32'h1);
        chk("lap_disp", {8'h0, o_disp_bcd}, 32'h000123);
        cyc(769);
        chk("lap_live_200", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h000200);
        chk("lap_disp_frozen", {8'h0, o_disp_bcd}, 32'h000123);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk("unlap_disp", {8'h0, o_disp_bcd}, 32'h000200);
        chk("unlap_hold", {31'h0, o_lap_hold_h}, 32'h0);
        // lap on the same edge as a tick captures the pre-increment value
        watch_rst = 1'b1;
        cyc(1);
        watch_rst = 1'b0;
        cyc(99);
        chk("tlap_pre_cs", {24'h0, o_cs_bcd}, 32'h09);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk("tlap_disp", {8'h0, o_disp_bcd}, 32'h000009);
        chk("tlap_live", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h000010);
        chk("tlap_flags", {30'h0, o_tick_h, o_lap_hold_h}, 32'h3);
        cyc(9);
        chk("tlap_disp_held", {8'h0, o_disp_bcd}, 32'h000009);
        // watch reset beats a pending tick and clears hold
        watch_rst = 1'b1;
        cyc(1);
        watch_rst = 1'b0;
        chk("wrst2_live", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h0);
        chk("wrst2_flags", {o_disp_bcd, o_tick_h, o_lap_hold_h, o_wrap_h}, 32'h0);
        // carry 00:59.99 -> 01:00.00
        cyc(59990);
        chk("carry_pre", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h005999);
        cyc(10);
        chk("carry_min", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h010000);
        chk("carry_wrap0", {31'h0, o_wrap_h}, 32'h0);
        // full wrap from 59:59.99
        force dut.u_min.value_q = 8'h59;
        force dut.u_sec.value_q = 8'h59;
        force dut.u_cs.value_q  = 8'h99;
        #1;
        release dut.u_min.value_q;
        release dut.u_sec.value_q;
        release dut.u_cs.value_q;
        cyc(9);
        chk("wrap_pre", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h595999);
        chk("wrap_pre_flag", {31'h0, o_wrap_h}, 32'h0);
        cyc(1);
        chk("wrap_live", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h0);
        chk("wrap_flags", {30'h0, o_tick_h, o_wrap_h}, 32'h3);
        cyc(1);
        chk("wrap_pulse_end", {30'h0, o_tick_h, o_wrap_h}, 32'h0);
        cyc(9);
        chk("post_wrap_cs", {8'h0, o_min_bcd, o_sec_bcd, o_cs_bcd}, 32'h000001);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stop_watch_counter.md
Name: stop_watch_counter

Overview:
Timekeeping datapath driven by the stopwatch control FSM outputs (watch running / watch reset). Divides the system clock down to a 10 ms tick and accumulates elapsed time as BCD minutes:seconds:centiseconds. Provides a lap-hold display path so the shown value can be frozen while counting continues. Sits between the stopwatch control FSM and the 7-segment display driver.

Parameters:
CLK_HZ, 1000000, system clock frequency in Hz
TICK_HZ, 100, count tick rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, >= 2
DIV_W, $clog2(CLK_HZ/TICK_HZ), prescaler width (derived, not overridden)

Ports:
i_clk_h  in  1  system clock, rising edge
i_sys_rst_l  in  1  asynchronous active-low reset
i_watch_running_h  in  1  level; count while high
i_watch_rst_h  in  1  level; clear time while high
i_lap_h  in  1  single-cycle pulse; toggles lap hold
o_tick_h  out  1  one-cycle pulse on each counted 10 ms tick
o_cs_bcd  out  8  live centiseconds, two BCD digits, 00-99
o_sec_bcd  out  8  live seconds, two BCD digits, 00-59
o_min_bcd  out  8  live minutes, two BCD digits, 00-59
o_disp_bcd  out  24  display value {min,sec,cs}; live, or frozen while lap hold is active
o_lap_hold_h  out  1  lap hold active
o_wrap_h  out  1  one-cycle pulse when time wraps 59:59.99 -> 00:00.00

Behaviour:
- Reset is asynchronous on i_sys_rst_l low: prescaler 0, all BCD digits 0, o_disp_bcd 0, o_tick_h 0, o_lap_hold_h 0, o_wrap_h 0. All outputs are registered.
- Priority per cycle: i_watch_rst_h > i_watch_running_h > idle.
- Watch reset (i_watch_rst_h=1): next edge clears the prescaler, all digits, lap hold and the display register. o_tick_h and o_wrap_h are 0. This applies regardless of running.
- Running (i_watch_running_h=1, reset low): the prescaler increments each cycle. When it equals DIV-1, it returns to 0, o_tick_h=1 for that cycle, and time advances by 1 cs on the same edge.
- The first tick occurs DIV cycles after running is first sampled high from a cleared state.
- Idle (both low): the prescaler and digits hold; the partial tick is retained, so stop/resume loses no sub-tick time.
- BCD carry chain: cs units 9->0 carries into cs tens; cs 99->00 carries into sec units; sec tens 5 with units 9 -> 00 carries into min; min 59 -> 00.
- Full wrap 59:59.99 -> 00:00.00 pulses o_wrap_h for one cycle, coincident with o_tick_h. Counting continues after the wrap.
- Digits never leave the ranges 0-9 (units), 0-9 (cs tens), 0-5 (sec/min tens).
- Lap: an i_lap_h pulse with reset low toggles lap hold.
  - Entering hold: o_disp_bcd captures the live value as it is *before* that edge's update. If a tick lands on the same edge, the displayed value is the pre-increment value.
  - While holding: o_disp_bcd is frozen and the live outputs keep counting.
  - Leaving hold: o_disp_bcd follows live again from the next cycle.
  - Lap is accepted whether running or idle.
- Display when not holding: o_disp_bcd = {o_min_bcd, o_sec_bcd, o_cs_bcd}, registered, so it lags the live outputs by 1 cycle.
- i_lap_h coincident with i_watch_rst_h: ignored; reset wins and hold is cleared.
- i_watch_running_h and i_watch_rst_h both high (illegal from the FSM): treated as reset.

Decomposition:
- Shared package stop_watch_pkg:
  - encoding constants of the control FSM states (zero/counting/stop);
  - BCD limit constants (CS_MAX=99, SEC_MAX=59, MIN_MAX=59);
  - a 24-bit time typedef {min,sec,cs}.
- One natural sub-module, bcd_digit_pair: a two-digit BCD counter with parameter MAX_TENS/MAX_UNITS, inputs inc/clr, outputs value and carry. It is instantiated three times in a chain.
- The prescaler and lap register stay in the top level.

Test Plan:
(all with CLK_HZ=1000, TICK_HZ=100, so DIV=10)
- Async reset: drop i_sys_rst_l mid-count at 00:03.47 -> all outputs 0 immediately, with no clock edge needed.
- Running held 25 cycles from clear -> o_tick_h pulses at cycles 10 and 20, and o_cs_bcd=8'h02.
- Run 7 cycles, idle 50 cycles, run 3 cycles -> exactly one tick, on the 3rd resumed cycle; o_cs_bcd=8'h01.
- Carry: preload via counting to 00:59.99, then one tick -> 01:00.00. From 59:59.99, one tick -> 00:00.00 with o_wrap_h=1 for 1 cycle.
- Lap at 00:01.23 -> o_disp_bcd=24'h000123 held while the live count reaches 00:02.00; a second lap pulse -> o_disp_bcd=24'h000200 on the following cycle.
- Lap pulse on the same edge as a tick (live 00:00.09 -> 00:00.10) -> the held display is 24'h000009. i_watch_rst_h with running high -> all cleared, o_lap_hold_h=0, no tick.
